// File: rtl/ili9341_rgb_timing.sv
// ILI9341 RGB-interface raster timing: walks sync/back-porch/active/front-porch per line and per frame,
// one raster position per pixel_tick, and drives the panel one tick behind the video-memory address.
module ili9341_rgb_timing #(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int HSW            = 10,
    parameter int HBP            = 20,
    parameter int HFP            = 10,
    parameter int VSW            = 2,
    parameter int VBP            = 2,
    parameter int VFP            = 4,
    parameter int WIDTH_BITS     = $clog2(DISPLAY_WIDTH),
    parameter int HEIGHT_BITS    = $clog2(DISPLAY_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pixel_tick,
    input  logic                   enable,
    input  logic [15:0]            pixel_in,
    output logic [WIDTH_BITS-1:0]  display_x,
    output logic [HEIGHT_BITS-1:0] display_y,
    output logic                   in_display_region,
    output logic                   hsync_n,
    output logic                   vsync_n,
    output logic                   de,
    output logic [15:0]            rgb,
    output logic                   frame_start
);
    localparam int CW_XY = (WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS;
    localparam int CW    = (CW_XY > 8) ? CW_XY : 8;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} run_state_t;
    typedef enum logic [1:0] {PH_SYNC = 2'd0, PH_BACK = 2'd1, PH_ACTIVE = 2'd2, PH_FRONT = 2'd3} phase_t;

    function automatic logic [CW-1:0] h_last(input phase_t ph);
        case (ph)
            PH_SYNC:   return CW'(HSW - 1);
            PH_BACK:   return CW'(HBP - 1);
            PH_ACTIVE: return CW'(DISPLAY_WIDTH - 1);
            PH_FRONT:  return CW'(HFP - 1);
            default:   return CW'(HSW - 1);
        endcase
    endfunction

    function automatic logic [CW-1:0] v_last(input phase_t ph);
        case (ph)
            PH_SYNC:   return CW'(VSW - 1);
            PH_BACK:   return CW'(VBP - 1);
            PH_ACTIVE: return CW'(DISPLAY_HEIGHT - 1);
            PH_FRONT:  return CW'(VFP - 1);
            default:   return CW'(VSW - 1);
        endcase
    endfunction

    function automatic phase_t next_phase(input phase_t ph);
        case (ph)
            PH_SYNC:   return PH_BACK;
            PH_BACK:   return PH_ACTIVE;
            PH_ACTIVE: return PH_FRONT;
            PH_FRONT:  return PH_SYNC;
            default:   return PH_SYNC;
        endcase
    endfunction

    run_state_t             run_q, run_d;
    phase_t                 h_state_q, h_state_d, v_state_q, v_state_d;
    logic [CW-1:0]          h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [WIDTH_BITS-1:0]  display_x_q, display_x_d;
    logic [HEIGHT_BITS-1:0] display_y_q, display_y_d;
    logic                   in_display_region_q, in_display_region_d;
    logic                   hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d, de_q, de_d;
    logic [15:0]            rgb_q, rgb_d;
    logic                   frame_start_q, frame_start_d;
    logic                   h_end_s, v_end_s, frame_end_s;

    // Next-state logic: raster walk, region outputs from the new position, panel outputs from the old one
    always_comb begin
        run_d               = run_q;
        h_state_d           = h_state_q;
        v_state_d           = v_state_q;
        h_cnt_d             = h_cnt_q;
        v_cnt_d             = v_cnt_q;
        display_x_d         = display_x_q;
        display_y_d         = display_y_q;
        in_display_region_d = in_display_region_q;
        hsync_n_d           = hsync_n_q;
        vsync_n_d           = vsync_n_q;
        de_d                = de_q;
        rgb_d               = rgb_q;
        frame_start_d       = 1'b0;
        h_end_s             = (h_cnt_q == h_last(h_state_q));
        v_end_s             = (v_cnt_q == v_last(v_state_q));
        frame_end_s         = h_end_s && v_end_s && (h_state_q == PH_FRONT) && (v_state_q == PH_FRONT);
        if (pixel_tick) begin
            // pixel_in now holds the memory word addressed by the previous tick's region outputs
            hsync_n_d = !((run_q == ST_RUN) && (h_state_q == PH_SYNC));
            vsync_n_d = !((run_q == ST_RUN) && (v_state_q == PH_SYNC));
            de_d      = in_display_region_q;
            rgb_d     = in_display_region_q ? pixel_in : 16'd0;
            case (run_q)
                ST_IDLE: begin
                    if (enable) begin
                        run_d         = ST_RUN;
                        frame_start_d = 1'b1;
                    end else begin
                        run_d = ST_IDLE;
                    end
                    h_state_d = PH_SYNC;
                    h_cnt_d   = '0;
                    v_state_d = PH_SYNC;
                    v_cnt_d   = '0;
                end
                ST_RUN: begin
                    if (h_end_s) begin
                        h_state_d = next_phase(h_state_q);
                        h_cnt_d   = '0;
                    end else begin
                        h_cnt_d = h_cnt_q + CW'(1);
                    end
                    if (h_end_s && (h_state_q == PH_FRONT)) begin
                        if (v_end_s) begin
                            v_state_d = next_phase(v_state_q);
                            v_cnt_d   = '0;
                        end else begin
                            v_cnt_d = v_cnt_q + CW'(1);
                        end
                    end else begin
                        v_cnt_d = v_cnt_q;
                    end
                    // The natural wrap already lands on sync line 0; enable only decides whether to stay
                    if (frame_end_s) begin
                        if (enable) begin
                            frame_start_d = 1'b1;
                        end else begin
                            run_d = ST_IDLE;
                        end
                    end else begin
                        run_d = ST_RUN;
                    end
                end
                default: begin
                    run_d = ST_IDLE;
                end
            endcase
            if (run_d == ST_RUN) begin
                in_display_region_d = (h_state_d == PH_ACTIVE) && (v_state_d == PH_ACTIVE);
                display_x_d = (h_state_d == PH_ACTIVE) ? h_cnt_d[WIDTH_BITS-1:0] : '0;
                if (v_state_d == PH_ACTIVE) begin
                    display_y_d = v_cnt_d[HEIGHT_BITS-1:0];
                end else if (v_state_d == PH_SYNC) begin
                    display_y_d = '0;
                end else begin
                    display_y_d = display_y_q;
                end
            end else begin
                in_display_region_d = 1'b0;
                display_x_d         = '0;
                display_y_d         = '0;
            end
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q               <= ST_IDLE;
            h_state_q           <= PH_SYNC;
            v_state_q           <= PH_SYNC;
            h_cnt_q             <= '0;
            v_cnt_q             <= '0;
            display_x_q         <= '0;
            display_y_q         <= '0;
            in_display_region_q <= 1'b0;
            hsync_n_q           <= 1'b1;
            vsync_n_q           <= 1'b1;
            de_q                <= 1'b0;
            rgb_q               <= 16'd0;
            frame_start_q       <= 1'b0;
        end else begin
            run_q               <= run_d;
            h_state_q           <= h_state_d;
            v_state_q           <= v_state_d;
            h_cnt_q             <= h_cnt_d;
            v_cnt_q             <= v_cnt_d;
            display_x_q         <= display_x_d;
            display_y_q         <= display_y_d;
            in_display_region_q <= in_display_region_d;
            hsync_n_q           <= hsync_n_d;
            vsync_n_q           <= vsync_n_d;
            de_q                <= de_d;
            rgb_q               <= rgb_d;
            frame_start_q       <= frame_start_d;
        end
    end

    assign display_x         = display_x_q;
    assign display_y         = display_y_q;
    assign in_display_region = in_display_region_q;
    assign hsync_n           = hsync_n_q;
    assign vsync_n           = vsync_n_q;
    assign de                = de_q;
    assign rgb               = rgb_q;
    assign frame_start       = frame_start_q;

endmodule

// File: tb/tb_ili9341_rgb_timing.sv
// Scoreboard bench for ili9341_rgb_timing on a shrunken raster: a position-arithmetic model queues the
// expected outputs per tick, and an independent monitor pops and compares after each clock edge.
module tb_ili9341_rgb_timing;
    localparam int TW    = 20;
    localparam int TH    = 10;
    localparam int THSW  = 3;
    localparam int THBP  = 5;
    localparam int THFP  = 4;
    localparam int TVSW  = 2;
    localparam int TVBP  = 2;
    localparam int TVFP  = 3;
    localparam int WB    = $clog2(TW);
    localparam int HB    = $clog2(TH);
    localparam int HS0   = THSW + THBP;
    localparam int VS0   = TVSW + TVBP;
    localparam int LINE  = THSW + THBP + TW + THFP;
    localparam int FRAME = (TVSW + TVBP + TH + TVFP) * LINE;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] rgb;
        logic        fs;
        logic        ind;
        logic [7:0]  dx;
        logic [7:0]  dy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pixel_tick;
    logic          enable;
    logic [15:0]   pixel_in;
    logic [WB-1:0] display_x;
    logic [HB-1:0] display_y;
    logic          in_display_region, hsync_n, vsync_n, de, frame_start;
    logic [15:0]   rgb;
    logic [15:0]   mask;

    exp_t exp_q[$];
    exp_t hold_exp;
    logic mon_tick;
    int   checks   = 0;
    int   failures = 0;
    bit   m_run    = 1'b0;
    int   m_t      = 0;
    int   m_dy     = 0;

    ili9341_rgb_timing #(
        .DISPLAY_WIDTH(TW), .DISPLAY_HEIGHT(TH),
        .HSW(THSW), .HBP(THBP), .HFP(THFP),
        .VSW(TVSW), .VBP(TVBP), .VFP(TVFP)
    ) dut (
        .clk(clk), .reset(rst_n), .pixel_tick(pixel_tick), .enable(enable), .pixel_in(pixel_in),
        .display_x(display_x), .display_y(display_y), .in_display_region(in_display_region),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .rgb(rgb), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Video memory stand-in: word for the addressed (x,y), ready before the next tick
    assign pixel_in = {8'(display_y), 8'(display_x)} ^ mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic compare_all(input exp_t e, input bit is_tick);
        check("hsync_n", 32'(hsync_n), 32'(e.hs));
        check("vsync_n", 32'(vsync_n), 32'(e.vs));
        check("de", 32'(de), 32'(e.de));
        check("rgb", 32'(rgb), 32'(e.rgb));
        check("frame_start", 32'(frame_start), is_tick ? 32'(e.fs) : 32'd0);
        check("in_display_region", 32'(in_display_region), 32'(e.ind));
        check("display_x", 32'(display_x), 32'(e.dx));
        check("display_y", 32'(display_y), 32'(e.dy));
    endtask

    function automatic bit col_active(input int t);
        return ((t % LINE) >= HS0) && ((t % LINE) < HS0 + TW);
    endfunction

    function automatic bit line_active(input int t);
        return ((t / LINE) >= VS0) && ((t / LINE) < VS0 + TH);
    endfunction

    function automatic logic [15:0] pixel_at(input int t);
        return {8'((t / LINE) - VS0), 8'((t % LINE) - HS0)} ^ mask;
    endfunction

    // Reference model: raster position is just a tick index inside the frame
    task automatic model_step();
        exp_t e;
        bit   prev_run;
        int   prev_t;
        prev_run = m_run;
        prev_t   = m_t;
        e.fs     = 1'b0;
        if (!m_run) begin
            if (enable === 1'b1) begin
                m_run = 1'b1;
                m_t   = 0;
                e.fs  = 1'b1;
            end
        end else if (m_t == FRAME - 1) begin
            if (enable === 1'b1) begin
                m_t  = 0;
                e.fs = 1'b1;
            end else begin
                m_run = 1'b0;
            end
        end else begin
            m_t++;
        end
        e.hs  = !(prev_run && ((prev_t % LINE) < THSW));
        e.vs  = !(prev_run && ((prev_t / LINE) < TVSW));
        e.de  = prev_run && col_active(prev_t) && line_active(prev_t);
        e.rgb = e.de ? pixel_at(prev_t) : 16'd0;
        if (m_run) begin
            e.ind = col_active(m_t) && line_active(m_t);
            e.dx  = col_active(m_t) ? 8'((m_t % LINE) - HS0) : 8'd0;
            if (line_active(m_t)) begin
                m_dy = (m_t / LINE) - VS0;
            end else if ((m_t / LINE) < TVSW) begin
                m_dy = 0;
            end
        end else begin
            e.ind = 1'b0;
            e.dx  = 8'd0;
            m_dy  = 0;
        end
        e.dy = 8'(m_dy);
        exp_q.push_back(e);
    endtask

    task automatic do_tick();
        int gap;
        model_step();
        pixel_tick = 1'b1;
        @(negedge clk);
        gap = $urandom_range(0, 3);
        if (gap != 0) begin
            pixel_tick = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic quiesce();
        pixel_tick = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: every edge with a tick consumes one expectation; other edges must hold the last one
    always @(posedge clk) begin
        mon_tick = pixel_tick;
        if (rst_n === 1'b1) begin
            #1;
            if (mon_tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow: got tick with empty queue at %0t", $time);
                end else begin
                    hold_exp = exp_q.pop_front();
                    compare_all(hold_exp, 1'b1);
                end
            end else begin
                compare_all(hold_exp, 1'b0);
            end
        end
    end

    // Reset values must appear as soon as reset asserts, before any clock edge
    always @(negedge rst_n) begin
        #1;
        hold_exp = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 16'd0, fs: 1'b0, ind: 1'b0, dx: 8'd0, dy: 8'd0};
        compare_all(hold_exp, 1'b0);
    end

    initial begin
        int stop_line;
        int tx;
        int ty;
        int target;
        rst_n      = 1'b1;
        pixel_tick = 1'b0;
        enable     = 1'b0;
        mask       = 16'($urandom);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) do_tick();
        enable = 1'b1;
        for (int i = 0; i < 2 * FRAME + 40; i++) do_tick();

        // Drop enable part-way through the third frame; it must still run out through the front porch
        stop_line = $urandom_range(VS0, VS0 + TH - 1);
        for (int i = 0; i < FRAME && m_t != stop_line * LINE; i++) do_tick();
        enable = 1'b0;
        for (int i = 0; i < FRAME + 30; i++) do_tick();
        enable = 1'b1;
        for (int i = 0; i < 100; i++) do_tick();

        // Reset in the middle of an active line, away from any clock edge
        tx     = $urandom_range(0, TW - 1);
        ty     = $urandom_range(0, TH - 1);
        target = (VS0 + ty) * LINE + HS0 + tx;
        for (int i = 0; i < 2 * FRAME && !(m_run && m_t == target); i++) do_tick();
        quiesce();
        #2 rst_n = 1'b0;
        m_run = 1'b0;
        m_t   = 0;
        m_dy  = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < FRAME + 50; i++) do_tick();

        quiesce();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ili9341_rgb_timing.md
Name: ili9341_rgb_timing

Overview:
- Generates ILI9341 RGB-interface raster timing: HSYNC/VSYNC/DE plus the pixel bus.
- Sits directly downstream of the SPI video memory. It drives that block's display_x, display_y and in_display_region inputs, samples its current_pixel output, and presents it to the panel.
- Advances one pixel per pixel_tick strobe, all in the single system clock domain.

Parameters:
- DISPLAY_WIDTH, 240, active pixels per line
- DISPLAY_HEIGHT, 320, active lines per frame
- HSW, 10, hsync width in ticks
- HBP, 20, horizontal back porch in ticks
- HFP, 10, horizontal front porch in ticks
- VSW, 2, vsync width in lines
- VBP, 2, vertical back porch in lines
- VFP, 4, vertical front porch in lines
- WIDTH_BITS, $clog2(DISPLAY_WIDTH), width of display_x
- HEIGHT_BITS, $clog2(DISPLAY_HEIGHT), width of display_y

Ports:
- clk  input  1  system clock; all logic on posedge
- reset  input  1  asynchronous, active-low reset
- pixel_tick  input  1  single-clk strobe; one raster position per strobe
- enable  input  1  run request; sampled only at frame boundary
- pixel_in  input  16  RGB565 from video memory (current_pixel)
- display_x  output  WIDTH_BITS  active column of current position
- display_y  output  HEIGHT_BITS  active row of current position
- in_display_region  output  1  current position inside active area
- hsync_n  output  1  panel HSYNC, active-low
- vsync_n  output  1  panel VSYNC, active-low
- de  output  1  panel data enable
- rgb  output  16  panel pixel data
- frame_start  output  1  one-clk pulse when a frame begins

Behaviour:
- Reset (async assert, sync release):
  - Engine in IDLE.
  - display_x=0, display_y=0, in_display_region=0.
  - hsync_n=1, vsync_n=1, de=0, rgb=0, frame_start=0.
- Top FSM: IDLE -> RUN when enable=1 on a pixel_tick. RUN -> IDLE when enable=0 at the last tick of the last VFP line. Otherwise RUN loops frames.
- Entering RUN:
  - h_state=HSYNC, h_cnt=0; v_state=VSYNC, v_cnt=0.
  - frame_start pulses for 1 clk on that tick.
- Horizontal FSM, advances only on pixel_tick:
  - HSYNC(HSW) -> HBP(HBP) -> ACTIVE(DISPLAY_WIDTH) -> HFP(HFP) -> HSYNC.
  - h_cnt counts 0..len-1 within a state, then clears on transition.
  - Line = 280 ticks with defaults.
- Vertical FSM, advances on the tick that ends HFP:
  - VSYNC(VSW) -> VBP(VBP) -> ACTIVE(DISPLAY_HEIGHT) -> VFP(VFP) -> VSYNC.
  - Frame = 328 lines with defaults.
  - frame_start pulses on the tick that re-enters VSYNC line 0 while in RUN.
- Region outputs: registered, and updated on the same clk edge as the state change.
  - in_display_region = (h_state==ACTIVE && v_state==ACTIVE).
  - display_x = h_cnt while h ACTIVE, else 0.
  - display_y = v_cnt while v ACTIVE, else held at the last value. It resets to 0 on entering VSYNC.
- Panel outputs: registered on pixel_tick and lag the region outputs by exactly one tick, covering the memory read latency.
  - hsync_n = !(h_state==HSYNC) at the previous tick.
  - vsync_n = !(v_state==VSYNC) at the previous tick.
  - de = previous in_display_region.
  - rgb = pixel_in if previous in_display_region, else 0.
  - Between ticks, all outputs hold.
- IDLE: panel outputs hold the reset values and region outputs are 0. The pixel_in value is ignored.
- enable deassert mid-frame: the current frame completes unchanged. Entering IDLE leaves de=0 and hsync_n=vsync_n=1 after the final lag tick.
- Reset mid-frame: immediate return to the reset values; there is no partial-line recovery.
- pixel_tick on consecutive clks is legal; each strobe is one position.
- Widths: counters use max(WIDTH_BITS, HEIGHT_BITS, 8) bits internally. Parameters of 0 are illegal.

Test Plan:
- Reset, then enable=1 with tick every 4 clks -> frame_start pulses once; hsync_n low for exactly 10 ticks; de first high at tick 30 of VSYNC+VBP-offset line 4 (one tick after in_display_region).
- Count one full line -> 280 ticks between hsync_n falling edges; de high for exactly 240 consecutive ticks; display_x runs 0..239.
- Count one frame -> 328 hsync pulses per vsync pulse; vsync_n low for 2 lines; display_y runs 0..319; 240*320 de-high ticks.
- pixel_in = {display_y[7:0], display_x[7:0]} modelled with a 1-tick latency -> rgb at each de-high tick equals the expected (x,y); rgb=0 whenever de=0.
- enable=0 asserted at line 100 -> frame finishes through VFP; no further frame_start; hsync_n=vsync_n=1, de=0 thereafter; re-enable restarts at HSYNC/VSYNC.
- reset pulsed low mid-active line (x=57, y=200) -> all outputs at reset values within the assert, independent of clk; after release with enable=1 the first frame timing is identical to the first scenario.
